ifu_sa: RTL and testbench
=========================

Name: ifu_sa

Overview:
Parametrised instruction fetch unit with an integrated N-way set-associative instruction cache. It is the successor to the direct-mapped fetch front end, generalised in address width, line width, set count and associativity, and it adds round-robin replacement and a fetch-request qualifier. It sits between the core's fetch stage and the memory/bus read port. Refill is a single-line blocking miss handled by an IDLE/MISS/FILL state machine.

Parameters:
ADDR_W, 32, instruction address width
LINE_W, 64, cache line width in bits; power of two, at least 32; OFF_W = log2(LINE_W/8)
SETS, 64, number of sets; power of two; IDX_W = log2(SETS)
WAYS, 2, associativity; power of two, 1 to 8; TAG_W = ADDR_W - IDX_W - OFF_W

Ports:
clk  in  1  clock; all state updates on the rising edge
rstn  in  1  synchronous, active-low reset
fetch_req  in  1  core requests a fetch at instr_addr this cycle
instr_addr  in  ADDR_W  fetch address; the low OFF_W bits are ignored for lookup
ifu_data  out  LINE_W  fetched line
instr_valid  out  1  ifu_data is valid for instr_addr this cycle
ifu_miss  out  1  high while state == MISS
fencei_flush  in  1  invalidate the whole cache
mem_req  out  1  refill read request, held until accepted
mem_addr  out  ADDR_W  line-aligned refill address; low OFF_W bits are 0
mem_rdata  in  LINE_W  refill data
mem_rvalid  in  1  refill data valid; one pulse completes the request

Behaviour:
- Storage: per set and per way, a valid bit, a TAG_W tag and a LINE_W data word, all in flops. Per set, a log2(WAYS)-bit round-robin pointer (none when WAYS = 1).
- Lookup (combinational): idx = instr_addr[IDX_W+OFF_W-1:OFF_W], tag = upper TAG_W bits. hit = any way with valid and a tag match; there is never more than one match. ifu_data is the matching way's data.
- Reset (rstn = 0 at an edge): state = IDLE, all valid bits = 0, all pointers = 0, mem_req = 0, latched address = 0. Outputs after reset: instr_valid = 0, ifu_miss = 0, mem_addr = 0, ifu_data = 0.
- State IDLE:
  - instr_valid = fetch_req & hit. Zero added latency on a hit.
  - fetch_req & !hit: at the next edge, latch the line-aligned instr_addr into miss_addr, set mem_req = 1, go to MISS.
- State MISS:
  - ifu_miss = 1, instr_valid = 0, mem_addr = miss_addr, mem_req held at 1. Changes on instr_addr are ignored.
  - On mem_rvalid, at the edge: mem_req = 0, capture mem_rdata into fill_buf, install the line (unless install is suppressed, see flush rules), go to FILL.
- Install rule: the victim is the lowest-index invalid way of the set. If no way is invalid, the victim is the way at the set's pointer, and that pointer increments modulo WAYS. Filling an invalid way leaves the pointer unchanged.
- State FILL (exactly 1 cycle):
  - ifu_data = fill_buf.
  - instr_valid = fetch_req & (line-aligned instr_addr == miss_addr).
  - Always return to IDLE at the next edge. If the core moved to another line, it is looked up again in IDLE.
- fencei_flush: at the edge where it is high, all valid bits and pointers are cleared. It has priority over a simultaneous install.
  - If seen in MISS, or in the same cycle as mem_rvalid, set a suppress flag. The in-flight line is still delivered in FILL but is not installed.
  - The suppress flag clears on entering IDLE.
  - While fencei_flush is high in IDLE, instr_valid = 0.
- mem_rvalid outside MISS is ignored. rstn low during MISS abandons the refill: mem_req drops at that edge.

Optional Feature:
IFU_PERF_CNT_EN.
- When defined: adds output ports hit_cnt [31:0] and miss_cnt [31:0], both reset to 0.
  - hit_cnt increments on each IDLE cycle with fetch_req & hit.
  - miss_cnt increments on each IDLE→MISS transition.
  - Both wrap modulo 2^32 and are unaffected by fencei_flush.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Cold miss: reset, fetch_req = 1, instr_addr = 0x100. Expect ifu_miss = 1 and mem_req = 1 with mem_addr = 0x100. Return mem_rvalid with 0xDEADBEEF_CAFEF00D after 3 cycles. Expect one FILL cycle with instr_valid = 1 and that data, then a re-fetch of 0x104 hits in IDLE with zero latency.
- Associativity (WAYS = 2, SETS = 64): fill 0x0000, 0x0200 and 0x0400, which all map to idx 0. The third fill evicts way 0 (pointer 0→1). Then 0x0200 hits, 0x0000 misses, and that refill evicts way 1.
- Fencei during refill: miss on 0x300, assert fencei_flush for 1 cycle in MISS, return data. Expect FILL to deliver the data with instr_valid = 1, and the next fetch of 0x300 to miss again.
- Address change during miss: miss on 0x100, switch instr_addr to 0x800 during MISS. Expect mem_addr to stay 0x100, instr_valid = 0 in FILL, then a new miss for 0x800.
- Reset mid-refill: rstn = 0 in MISS. Expect mem_req = 0, state IDLE and all lines invalid, so a fetch of 0x100 misses.
- With IFU_PERF_CNT_EN: 3 misses followed by 5 hits gives miss_cnt = 3 and hit_cnt = 5.

Source files
------------

// File: rtl/ifu_sa.sv
// ifu_sa: fetch unit with N-way set-associative I-cache, round-robin refill; IFU_PERF_CNT_EN adds hit/miss counters
module ifu_sa #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 64,
  parameter int SETS = 64,
  parameter int WAYS = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic [LINE_W-1:0] ifu_data,
  output logic              instr_valid,
  output logic              ifu_miss,
  input  logic              fencei_flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rvalid
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int PTR_W = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;
  state_t state;
  logic [WAYS-1:0] valid [SETS];
  logic [TAG_W-1:0] tags [SETS][WAYS];
  logic [LINE_W-1:0] data [SETS][WAYS];
  logic [PTR_W-1:0] ptr [SETS];
  logic [ADDR_W-1:0] miss_addr, line_addr;
  logic [LINE_W-1:0] fill_buf, hit_data;
  logic [IDX_W-1:0] idx, m_idx;
  logic [TAG_W-1:0] tag, m_tag;
  logic [PTR_W-1:0] victim;
  logic sup, hit, full, inst, unused_off;
  assign idx = instr_addr[IDX_W+OFF_W-1:OFF_W];
  assign tag = instr_addr[ADDR_W-1:IDX_W+OFF_W];
  assign m_idx = miss_addr[IDX_W+OFF_W-1:OFF_W];
  assign m_tag = miss_addr[ADDR_W-1:IDX_W+OFF_W];
  assign line_addr = {instr_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign unused_off = ^instr_addr[OFF_W-1:0];
  assign mem_addr = miss_addr;
  assign ifu_data = state == FILL ? fill_buf : hit_data;
  assign instr_valid = state == IDLE ? fetch_req & hit & ~fencei_flush :
                       state == FILL ? fetch_req & (line_addr == miss_addr) : 1'b0;
  assign inst = rstn & (state == MISS) & mem_rvalid & ~sup & ~fencei_flush;
  // tag compare across the ways of the addressed set; at most one way matches
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit = 1'b1;
        hit_data = hit_data | data[idx][w];
      end
  end
  // victim: lowest invalid way of the refill set, else the round-robin pointer
  always_comb begin
    full = 1'b1;
    victim = ptr[m_idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[m_idx][w]) begin
        victim = PTR_W'(w);
        full = 1'b0;
      end
  end
  // line payload and tag storage, written only on an installing refill
  always_ff @(posedge clk) begin
    if (inst) begin
      tags[m_idx][victim] <= m_tag;
      data[m_idx][victim] <= mem_rdata;
    end
  end
  // IDLE/MISS/FILL control, valid bits, replacement pointers; flush overrides install
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      mem_req <= 1'b0;
      ifu_miss <= 1'b0;
      miss_addr <= '0;
      fill_buf <= '0;
      sup <= 1'b0;
      valid <= '{default: '0};
      ptr <= '{default: '0};
    end else begin
      case (state)
        IDLE: if (fetch_req && !hit) begin
          miss_addr <= line_addr;
          mem_req <= 1'b1;
          ifu_miss <= 1'b1;
          state <= MISS;
        end
        MISS: begin
          if (fencei_flush) sup <= 1'b1;
          if (mem_rvalid) begin
            mem_req <= 1'b0;
            ifu_miss <= 1'b0;
            fill_buf <= mem_rdata;
            state <= FILL;
          end
          if (inst) begin
            valid[m_idx][victim] <= 1'b1;
            if (WAYS > 1 && full) ptr[m_idx] <= ptr[m_idx] + 1'b1;
          end
        end
        default: begin
          sup <= 1'b0;
          state <= IDLE;
        end
      endcase
      if (fencei_flush) begin
        valid <= '{default: '0};
        ptr <= '{default: '0};
      end
    end
  end
`ifdef IFU_PERF_CNT_EN
  // hit count per serviced IDLE fetch, miss count per IDLE->MISS entry
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else if (state == IDLE && fetch_req) begin
      hit_cnt <= hit_cnt + {31'd0, hit};
      miss_cnt <= miss_cnt + {31'd0, ~hit};
    end
  end
`endif
endmodule

// File: tb/tb_ifu_sa.sv
// tb_ifu_sa: randomized fetch/refill traffic against a set-associative cache model
module tb_ifu_sa;
  localparam int WAYS = 2;
  localparam int SETS = 64;
  logic clk = 1'b0, rstn = 1'b0, fetch_req = 1'b0, fencei_flush = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] instr_addr = '0, mem_addr;
  logic [63:0] ifu_data, mem_rdata = '0;
  logic instr_valid, ifu_miss, mem_req;
  int n_cmp = 0, n_bad = 0, m_hits = 0, m_misses = 0;
  bit m_valid [SETS][WAYS];
  logic [22:0] m_tag [SETS][WAYS];
  logic [63:0] m_data [SETS][WAYS];
  int m_ptr [SETS];
  bit h;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  ifu_sa dut (
    .clk(clk), .rstn(rstn), .fetch_req(fetch_req), .instr_addr(instr_addr),
    .ifu_data(ifu_data), .instr_valid(instr_valid), .ifu_miss(ifu_miss),
    .fencei_flush(fencei_flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
`ifdef IFU_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void m_clear();
    foreach (m_valid[s, w]) m_valid[s][w] = 0;
    foreach (m_ptr[s]) m_ptr[s] = 0;
  endfunction
  function automatic int m_find(input logic [31:0] a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[a[8:3]][w] && m_tag[a[8:3]][w] == a[31:9]) return w;
    return -1;
  endfunction
  function automatic void m_install(input logic [31:0] a, input logic [63:0] d);
    int s = int'(a[8:3]);
    int v = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
    if (v < 0) begin
      v = m_ptr[s];
      m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    end
    m_valid[s][v] = 1;
    m_tag[s][v] = a[31:9];
    m_data[s][v] = d;
  endfunction
  task automatic fetch(input logic [31:0] a, input logic [63:0] d, input int dly, input bit fl, output bit was_hit);
    logic [31:0] line = {a[31:3], 3'b000};
    int w;
    @(negedge clk);
    fetch_req = 1'b1;
    instr_addr = a;
    #2;
    w = m_find(a);
    was_hit = instr_valid;
    check("hit", instr_valid, w >= 0);
    if (w >= 0) begin
      check("hit_data", ifu_data, m_data[a[8:3]][w]);
      m_hits++;
      return;
    end
    m_misses++;
    for (int k = 0; k <= dly; k++) begin
      @(negedge clk);
      #2;
      check("miss_flag", ifu_miss, 1'b1);
      check("mem_req", mem_req, 1'b1);
      check("mem_addr", mem_addr, line);
      check("miss_valid", instr_valid, 1'b0);
      fencei_flush = fl && k == 0;
      mem_rvalid = k == dly;
      mem_rdata = d;
    end
    @(negedge clk);
    fencei_flush = 1'b0;
    mem_rvalid = 1'b0;
    #2;
    check("fill_valid", instr_valid, 1'b1);
    check("fill_data", ifu_data, d);
    check("fill_req", mem_req, 1'b0);
    if (fl) m_clear();
    else m_install(line, d);
  endtask
  initial begin
    bit [63:0] d;
    m_clear();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #2;
    check("rst_valid", instr_valid, 1'b0);
    check("rst_miss", ifu_miss, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_data", ifu_data, 64'h0);
    check("rst_req", mem_req, 1'b0);
    fetch(32'h100, 64'hDEADBEEF_CAFEF00D, 3, 0, h);
    check("cold_hit", h, 1'b0);
    fetch(32'h104, 64'h0, 0, 0, h);
    check("refetch_hit", h, 1'b1);
    check("refetch_data", ifu_data, 64'hDEADBEEF_CAFEF00D);
    fetch(32'h0000, 64'h1111, 1, 0, h);
    fetch(32'h0200, 64'h2222, 0, 0, h);
    fetch(32'h0400, 64'h4444, 2, 0, h);
    fetch(32'h0200, 64'h0, 0, 0, h);
    check("assoc_200_hit", h, 1'b1);
    fetch(32'h0000, 64'h5555, 0, 0, h);
    check("assoc_000_miss", h, 1'b0);
    fetch(32'h0200, 64'h2323, 0, 0, h);
    check("assoc_200_evicted", h, 1'b0);
    fetch(32'h300, 64'h3003, 2, 1, h);
    fetch(32'h300, 64'h3030, 1, 0, h);
    check("flush_remiss", h, 1'b0);
    @(negedge clk);
    fetch_req = 1'b1;
    instr_addr = 32'h1100;
    #2;
    check("chg_first", instr_valid, 1'b0);
    m_misses++;
    @(negedge clk);
    instr_addr = 32'h800;
    mem_rvalid = 1'b1;
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    #2;
    check("chg_mem_addr", mem_addr, 32'h1100);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #2;
    check("chg_fill_valid", instr_valid, 1'b0);
    check("chg_fill_data", ifu_data, 64'h0123_4567_89AB_CDEF);
    m_install(32'h1100, 64'h0123_4567_89AB_CDEF);
    fetch(32'h800, 64'h8008, 0, 0, h);
    check("chg_new_miss", h, 1'b0);
    fetch(32'h1100, 64'h0, 0, 0, h);
    check("chg_old_hit", h, 1'b1);
    fetch(32'h2100, 64'h0, 0, 0, h);
    @(negedge clk);
    fetch_req = 1'b1;
    instr_addr = 32'h4100;
    @(negedge clk);
    #2;
    check("rm_in_miss", ifu_miss, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    fetch_req = 1'b0;
    #2;
    check("rm_req", mem_req, 1'b0);
    check("rm_miss", ifu_miss, 1'b0);
    check("rm_addr", mem_addr, 32'h0);
    m_clear();
    m_hits = 0;
    m_misses = 0;
    fetch(32'h100, 64'hABCD, 1, 0, h);
    check("rm_refetch_miss", h, 1'b0);
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        fetch_req = 1'b0;
        fencei_flush = $urandom_range(0, 3) == 0;
        #2;
        check("idle_valid", instr_valid, 1'b0);
        if (fencei_flush) m_clear();
        @(negedge clk);
        fencei_flush = 1'b0;
      end
      d = {$urandom, $urandom};
      fetch({21'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 1)), 3'($urandom_range(0, 7))},
            d, $urandom_range(0, 3), $urandom_range(0, 7) == 0, h);
    end
`ifdef IFU_PERF_CNT_EN
    @(negedge clk);
    fetch_req = 1'b0;
    #2;
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
`endif
    @(negedge clk);
    fetch_req = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
